ecc_apb_master: RTL and testbench
=================================

Name: ecc_apb_master

Overview:
- APB initiator that drives the ECC_ENC_DEC register slave on behalf of a local command source.
- Takes one command per handshake: operation, codeword width, data and noise.
- Programs the slave's CODEWORD_WIDTH, DATA_IN and NOISE registers, then CTRL last. CTRL is last because the CTRL write starts the slave.
- Waits for operation_done, captures data_out and num_of_errors, and returns them as a held response. Sits between a test/host sequencer and the ECC block.

Parameters:
- AMBA_ADDR_WIDTH, 20, PADDR width.
- AMBA_WORD, 32, PWDATA width.
- DATA_WIDTH, 32, width of slave data_out and rsp_data.
- BASE_ADDR, 0, slave base byte address; register offsets are 0x0 CTRL, 0x4 DATA_IN, 0x8 CODEWORD_WIDTH, 0xC NOISE.
- TIMEOUT_CYCLES, 16, maximum cycles waited for operation_done.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  master idle, can accept a command.
- cmd_op  in  2  00 encode, 01 decode, 10 full channel, 11 illegal.
- cmd_width  in  2  codeword width code: 00 8b, 01 16b, 10 32b.
- cmd_data  in  AMBA_WORD  DATA_IN value.
- cmd_noise  in  AMBA_WORD  NOISE value.
- PADDR  out  AMBA_ADDR_WIDTH  APB address.
- PWDATA  out  AMBA_WORD  APB write data.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB write (always 1 during transfers).
- operation_done  in  1  slave completion pulse.
- data_out  in  DATA_WIDTH  slave result.
- num_of_errors  in  2  slave error count.
- rsp_valid  out  1  response held.
- rsp_ready  in  1  response consumed.
- rsp_data  out  DATA_WIDTH  captured data_out.
- rsp_errors  out  2  captured num_of_errors.
- rsp_status  out  2  00 ok, 01 timeout, 10 illegal op.

Behaviour:
- Reset (async, rst=0) forces all outputs to 0 and returns the state to IDLE immediately. Affected outputs: PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_*, and cmd_ready until the first clock after release.
- Reset mid-transfer aborts the transfer with no completion.
- States: IDLE, SETUP, ACCESS, WAIT_DONE, RESP.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready:
  - Latch all cmd fields.
  - If cmd_op==11: go to RESP with rsp_status=10, rsp_data=0, rsp_errors=0, and no APB traffic.
  - Otherwise: go to SETUP with write index = CODEWORD_WIDTH.
- Write sequence:
  - CODEWORD_WIDTH (PWDATA = {0, width}), then DATA_IN (cmd_data).
  - Then NOISE (cmd_noise), only when op==10.
  - Then CTRL (PWDATA = {0, op}).
- SETUP (1 cycle): PSEL=1, PENABLE=0, PWRITE=1, PADDR=BASE_ADDR+offset, PWDATA valid. Next state is ACCESS.
- ACCESS (1 cycle): PSEL=1, PENABLE=1, PADDR/PWDATA unchanged. The slave has no PREADY, so every access completes in this cycle.
- After ACCESS:
  - Next register pending: go to SETUP for it (back-to-back transfers, no idle cycle).
  - CTRL just written: go to WAIT_DONE with timeout counter cleared.
- PSEL/PENABLE are 0 in IDLE, WAIT_DONE and RESP. PADDR/PWDATA hold their last values there.
- Transfer counts: encode/decode = 3 transfers (6 cycles); full channel = 4 transfers (8 cycles).
- WAIT_DONE:
  - Counter increments each cycle.
  - On operation_done=1: capture data_out and num_of_errors in that same cycle, set rsp_status=00, go to RESP.
  - If the counter reaches TIMEOUT_CYCLES with no done: rsp_status=01, rsp_data=0, rsp_errors=0, go to RESP.
  - operation_done simultaneous with the timeout limit is treated as success.
- operation_done is ignored in every state except WAIT_DONE.
- RESP: rsp_valid=1; rsp_* stay stable until rsp_valid&rsp_ready, then go to IDLE. rsp_valid rises the cycle after capture.
- A new cmd is accepted no earlier than the cycle after the response handshake. cmd_ready=0 outside IDLE.
- Counter width is $clog2(TIMEOUT_CYCLES+1); no wrap is possible.

Test Plan:
1. Encode: cmd op=00, width=00, data=0xB, with a slave model asserting done 2 cycles after the CTRL access.
   -> APB sequence (0x8, 0x0), (0x4, 0xB), (0x0, 0x0), each exactly SETUP+ACCESS.
   -> No NOISE write.
   -> rsp_valid=1, rsp_status=00, rsp_data equal to model data_out=0xA5.
2. Full channel: op=10, width=10, noise=0x00000001.
   -> Four transfers ending with (0xC, 0x1) then (0x0, 0x2).
   -> rsp_errors=01 captured from the done cycle.
3. Timeout: the slave never asserts done.
   -> rsp_status=01 exactly TIMEOUT_CYCLES=16 cycles after entering WAIT_DONE.
   -> rsp_data=0.
4. Illegal op=11.
   -> PSEL stays 0.
   -> rsp_valid the cycle after accept, with rsp_status=10.
5. Backpressure and spurious done: rsp_ready held 0 for 5 cycles, and operation_done pulsed while in IDLE.
   -> rsp_* stable throughout; cmd_ready=0 until the handshake.
   -> The IDLE pulse is ignored.
6. Reset asserted during the DATA_IN ACCESS cycle.
   -> PSEL/PENABLE drop to 0 asynchronously, no rsp_valid.
   -> cmd_ready=1 the cycle after release.

Source files
------------

// File: rtl/ecc_apb_master.sv
// ecc_apb_master: APB initiator that programs the ECC_ENC_DEC register slave
// for one command at a time. It writes CODEWORD_WIDTH, DATA_IN, optionally
// NOISE, and CTRL last (the CTRL write starts the slave). It then waits for
// operation_done and returns a held response with a status code.
module ecc_apb_master #(
    parameter int                         AMBA_ADDR_WIDTH = 20,
    parameter int                         AMBA_WORD       = 32,
    parameter int                         DATA_WIDTH      = 32,
    parameter logic [AMBA_ADDR_WIDTH-1:0] BASE_ADDR       = '0,
    parameter int                         TIMEOUT_CYCLES  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    // command channel
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_op,
    input  logic [1:0]                 cmd_width,
    input  logic [AMBA_WORD-1:0]       cmd_data,
    input  logic [AMBA_WORD-1:0]       cmd_noise,
    // APB initiator
    output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    output logic [AMBA_WORD-1:0]       PWDATA,
    output logic                       PSEL,
    output logic                       PENABLE,
    output logic                       PWRITE,
    // slave status
    input  logic                       operation_done,
    input  logic [DATA_WIDTH-1:0]      data_out,
    input  logic [1:0]                 num_of_errors,
    // response channel
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DATA_WIDTH-1:0]      rsp_data,
    output logic [1:0]                 rsp_errors,
    output logic [1:0]                 rsp_status
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    // Slave register offsets.
    localparam logic [AMBA_ADDR_WIDTH-1:0] OFF_CTRL  = AMBA_ADDR_WIDTH'('h0);
    localparam logic [AMBA_ADDR_WIDTH-1:0] OFF_DATA  = AMBA_ADDR_WIDTH'('h4);
    localparam logic [AMBA_ADDR_WIDTH-1:0] OFF_CW    = AMBA_ADDR_WIDTH'('h8);
    localparam logic [AMBA_ADDR_WIDTH-1:0] OFF_NOISE = AMBA_ADDR_WIDTH'('hC);

    // Operation codes.
    localparam logic [1:0] OP_FULL    = 2'b10;
    localparam logic [1:0] OP_ILLEGAL = 2'b11;

    // Response status codes.
    localparam logic [1:0] RSP_OK      = 2'b00;
    localparam logic [1:0] RSP_TIMEOUT = 2'b01;
    localparam logic [1:0] RSP_ILLEGAL = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_WAIT_DONE,
        ST_RESP
    } state_t;

    // Which slave register the current/next APB transfer targets.
    typedef enum logic [1:0] {
        REG_CW,
        REG_DATA,
        REG_NOISE,
        REG_CTRL
    } reg_t;

    state_t                       state, state_next;
    reg_t                         reg_idx, idx_next;
    logic                         cmd_ready_q;

    logic [1:0]                   op_q;
    logic [1:0]                   width_q;
    logic [AMBA_WORD-1:0]         data_q;
    logic [AMBA_WORD-1:0]         noise_q;

    logic [CNT_W-1:0]             cnt;
    logic [CNT_W-1:0]             cnt_plus1;

    logic [AMBA_ADDR_WIDTH-1:0]   paddr_q, next_paddr;
    logic [AMBA_WORD-1:0]         pwdata_q, next_pwdata;

    logic [DATA_WIDTH-1:0]        rsp_data_q;
    logic [1:0]                   rsp_errors_q;
    logic [1:0]                   rsp_status_q;

    // Control strobes from the FSM to the datapath.
    logic                         accept;
    logic                         load_apb;
    logic                         cnt_clear;
    logic                         cnt_inc;
    logic                         cap_done;
    logic                         cap_timeout;
    logic                         cap_illegal;

    // Command fields used to build APB words: live inputs on the accept
    // cycle (nothing latched yet), latched copies afterwards.
    logic [1:0]                   src_op;
    logic [1:0]                   src_width;
    logic [AMBA_WORD-1:0]         src_data;
    logic [AMBA_WORD-1:0]         src_noise;

    assign cnt_plus1 = cnt + CNT_W'(1);

    // State register, target register index and registered cmd_ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            reg_idx     <= REG_CW;
            cmd_ready_q <= 1'b0;
        end else begin
            // NOTE: every clocked register uses non-blocking assignment so all
            // flops update together from values sampled at the same edge.
            state       <= state_next;
            reg_idx     <= idx_next;
            // Registered so cmd_ready stays low until the first clock after reset.
            cmd_ready_q <= (state_next == ST_IDLE);
        end
    end

    // Next-state logic and datapath control strobes.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_next  = state;
        idx_next    = reg_idx;
        accept      = 1'b0;
        load_apb    = 1'b0;
        cnt_clear   = 1'b0;
        cnt_inc     = 1'b0;
        cap_done    = 1'b0;
        cap_timeout = 1'b0;
        cap_illegal = 1'b0;

        case (state)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    accept = 1'b1;
                    if (cmd_op == OP_ILLEGAL) begin
                        cap_illegal = 1'b1;
                        state_next  = ST_RESP;
                    end else begin
                        idx_next   = REG_CW;
                        load_apb   = 1'b1;
                        state_next = ST_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                // No PREADY: every access completes in this cycle.
                if (reg_idx == REG_CTRL) begin
                    cnt_clear  = 1'b1;
                    state_next = ST_WAIT_DONE;
                end else begin
                    load_apb   = 1'b1;
                    state_next = ST_SETUP;
                    case (reg_idx)
                        REG_CW:   idx_next = REG_DATA;
                        REG_DATA: idx_next = (op_q == OP_FULL) ? REG_NOISE : REG_CTRL;
                        default:  idx_next = REG_CTRL;
                    endcase
                end
            end
            ST_WAIT_DONE: begin
                // Done on the last allowed cycle still counts as success.
                if (operation_done) begin
                    cap_done   = 1'b1;
                    state_next = ST_RESP;
                end else if (cnt_plus1 == CNT_W'(TIMEOUT_CYCLES)) begin
                    cap_timeout = 1'b1;
                    state_next  = ST_RESP;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Address and write data for the register the next transfer targets.
    always_comb begin
        src_op      = (state == ST_IDLE) ? cmd_op    : op_q;
        src_width   = (state == ST_IDLE) ? cmd_width : width_q;
        src_data    = (state == ST_IDLE) ? cmd_data  : data_q;
        src_noise   = (state == ST_IDLE) ? cmd_noise : noise_q;
        next_paddr  = BASE_ADDR + OFF_CTRL;
        next_pwdata = AMBA_WORD'(src_op);
        case (idx_next)
            REG_CW: begin
                next_paddr  = BASE_ADDR + OFF_CW;
                next_pwdata = AMBA_WORD'(src_width);
            end
            REG_DATA: begin
                next_paddr  = BASE_ADDR + OFF_DATA;
                next_pwdata = src_data;
            end
            REG_NOISE: begin
                next_paddr  = BASE_ADDR + OFF_NOISE;
                next_pwdata = src_noise;
            end
            default: begin
                next_paddr  = BASE_ADDR + OFF_CTRL;
                next_pwdata = AMBA_WORD'(src_op);
            end
        endcase
    end

    // Command latch, APB address/data hold registers and the done timeout counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q     <= '0;
            width_q  <= '0;
            data_q   <= '0;
            noise_q  <= '0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            cnt      <= '0;
        end else begin
            if (accept) begin
                op_q    <= cmd_op;
                width_q <= cmd_width;
                data_q  <= cmd_data;
                noise_q <= cmd_noise;
            end
            if (load_apb) begin
                paddr_q  <= next_paddr;
                pwdata_q <= next_pwdata;
            end
            if (cnt_clear) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt_plus1;
            end
        end
    end

    // Response capture; held stable while the response waits in RESP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_data_q   <= '0;
            rsp_errors_q <= '0;
            rsp_status_q <= RSP_OK;
        end else if (cap_done) begin
            rsp_data_q   <= data_out;
            rsp_errors_q <= num_of_errors;
            rsp_status_q <= RSP_OK;
        end else if (cap_timeout) begin
            rsp_data_q   <= '0;
            rsp_errors_q <= '0;
            rsp_status_q <= RSP_TIMEOUT;
        end else if (cap_illegal) begin
            rsp_data_q   <= '0;
            rsp_errors_q <= '0;
            rsp_status_q <= RSP_ILLEGAL;
        end
    end

    // Strobes decode straight from state so reset drops them asynchronously.
    assign PSEL       = (state == ST_SETUP) || (state == ST_ACCESS);
    assign PENABLE    = (state == ST_ACCESS);
    assign PWRITE     = PSEL;
    assign PADDR      = paddr_q;
    assign PWDATA     = pwdata_q;
    assign cmd_ready  = cmd_ready_q;
    assign rsp_valid  = (state == ST_RESP);
    assign rsp_data   = rsp_data_q;
    assign rsp_errors = rsp_errors_q;
    assign rsp_status = rsp_status_q;

endmodule

// File: tb/tb_ecc_apb_master.sv
// tb_ecc_apb_master: directed bench for ecc_apb_master with a small slave
// model that raises operation_done a programmable number of cycles after the
// CTRL access and presents data_out/num_of_errors only in that cycle.
module tb_ecc_apb_master;

    localparam int AW = 20;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'b00;
    logic [1:0]    cmd_width = 2'b00;
    logic [31:0]   cmd_data = '0;
    logic [31:0]   cmd_noise = '0;
    logic [AW-1:0] PADDR;
    logic [31:0]   PWDATA;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic          operation_done;
    logic [DW-1:0] data_out;
    logic [1:0]    num_of_errors;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_data;
    logic [1:0]    rsp_errors;
    logic [1:0]    rsp_status;

    int checks = 0;
    int errors = 0;

    // Slave model controls, driven by the test tasks.
    logic          done_en = 1'b0;
    int            done_delay = 2;
    logic [DW-1:0] model_data = '0;
    logic [1:0]    model_err = '0;
    logic          spurious_done = 1'b0;

    // Monitor state, written only by the monitor processes.
    int            cyc = 0;
    int            done_at = -1;
    logic          model_done = 1'b0;
    int            n_tr = 0;
    int            setup_cnt = 0;
    int            proto_err = 0;
    int            ctrl_cyc = 0;
    int            rise_cyc = 0;
    logic          was_setup = 1'b0;
    logic [AW-1:0] setup_addr = '0;
    logic [31:0]   setup_data = '0;
    logic          rsp_valid_d = 1'b0;
    logic [AW-1:0] tr_addr [64];
    logic [31:0]   tr_data [64];

    ecc_apb_master dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_width      (cmd_width),
        .cmd_data       (cmd_data),
        .cmd_noise      (cmd_noise),
        .PADDR          (PADDR),
        .PWDATA         (PWDATA),
        .PSEL           (PSEL),
        .PENABLE        (PENABLE),
        .PWRITE         (PWRITE),
        .operation_done (operation_done),
        .data_out       (data_out),
        .num_of_errors  (num_of_errors),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .rsp_errors     (rsp_errors),
        .rsp_status     (rsp_status)
    );

    always #5 clk = ~clk;

    // Slave outputs carry junk outside the done cycle to catch mistimed captures.
    assign operation_done = model_done | spurious_done;
    assign data_out       = model_done ? model_data : 32'hDEAD_BEEF;
    assign num_of_errors  = model_done ? model_err : 2'b11;

    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor and done scheduler, sampling mid-cycle.
    always @(negedge clk) begin
        model_done <= (cyc == done_at);
        if (PSEL && !PENABLE) begin
            setup_cnt  <= setup_cnt + 1;
            setup_addr <= PADDR;
            setup_data <= PWDATA;
        end
        if (PSEL && PENABLE) begin
            if (!was_setup || PADDR !== setup_addr || PWDATA !== setup_data || !PWRITE)
                proto_err <= proto_err + 1;
            if (n_tr < 64) begin
                tr_addr[n_tr] <= PADDR;
                tr_data[n_tr] <= PWDATA;
            end
            n_tr <= n_tr + 1;
            if (PADDR == '0) begin
                ctrl_cyc <= cyc;
                if (done_en) done_at <= cyc + done_delay;
            end
        end
        if (PSEL && PWRITE !== 1'b1) proto_err <= proto_err + 1;
        was_setup <= PSEL && !PENABLE;
        if (rsp_valid && !rsp_valid_d) rise_cyc <= cyc;
        rsp_valid_d <= rsp_valid;
    end

    // Hard stop if something hangs despite the bounded waits.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Offer a command once the master is ready; returns at the negedge after acceptance.
    task automatic drive_cmd(input logic [1:0] op, input logic [1:0] width,
                             input logic [31:0] data, input logic [31:0] noise);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL cmd_ready_wait: got %b expected 1", cmd_ready);
        end
        cmd_op    = op;
        cmd_width = width;
        cmd_data  = data;
        cmd_noise = noise;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Wait at negedges until rsp_valid, bounded.
    task automatic wait_rsp(input string name);
        int guard;
        guard = 0;
        while (!rsp_valid && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_rsp_wait: rsp_valid got %b expected 1", name, rsp_valid);
        end
    endtask

    // Consume the response (called at a negedge); checks the return to IDLE.
    task automatic handshake(input string name);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_after_hs: rsp_valid=%b cmd_ready=%b expected 0/1", name, rsp_valid, cmd_ready);
        end
    endtask

    task automatic check_rsp(input string name, input logic [1:0] st,
                             input logic [DW-1:0] d, input logic [1:0] e);
        checks++;
        if (rsp_status !== st || rsp_data !== d || rsp_errors !== e) begin
            errors++;
            $display("FAIL %s_rsp: status=%b data=%h errors=%b expected %b/%h/%b",
                     name, rsp_status, rsp_data, rsp_errors, st, d, e);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (PSEL !== 0 || PENABLE !== 0 || PWRITE !== 0 || PADDR !== '0 || PWDATA !== '0 ||
            rsp_valid !== 0 || rsp_data !== '0 || rsp_errors !== 0 || rsp_status !== 0 || cmd_ready !== 0) begin
            errors++;
            $display("FAIL reset_outputs: psel=%b pen=%b pw=%b paddr=%h pwdata=%h rv=%b rd=%h re=%b rs=%b cr=%b expected all 0",
                     PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_data, rsp_errors, rsp_status, cmd_ready);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_ready: got %b expected 0", cmd_ready);
        end
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_clock_ready: got %b expected 1", cmd_ready);
        end
    endtask

    task automatic test_encode();
        int b_tr, b_set;
        @(posedge clk);
        b_tr = n_tr; b_set = setup_cnt;
        done_en = 1'b1; done_delay = 2; model_data = 32'hA5; model_err = 2'b00;
        drive_cmd(2'b00, 2'b00, 32'h0000_000B, 32'h0000_0055);
        wait_rsp("encode");
        check_rsp("encode", 2'b00, 32'hA5, 2'b00);
        handshake("encode");
        @(posedge clk);
        checks++;
        if (n_tr - b_tr != 3 || setup_cnt - b_set != 3) begin
            errors++;
            $display("FAIL encode_count: transfers=%0d setups=%0d expected 3/3", n_tr - b_tr, setup_cnt - b_set);
        end
        checks++;
        if (tr_addr[b_tr] !== 20'h8 || tr_data[b_tr] !== 32'h0 ||
            tr_addr[b_tr+1] !== 20'h4 || tr_data[b_tr+1] !== 32'hB ||
            tr_addr[b_tr+2] !== 20'h0 || tr_data[b_tr+2] !== 32'h0) begin
            errors++;
            $display("FAIL encode_seq: (%h,%h) (%h,%h) (%h,%h) expected (8,0) (4,b) (0,0)",
                     tr_addr[b_tr], tr_data[b_tr], tr_addr[b_tr+1], tr_data[b_tr+1], tr_addr[b_tr+2], tr_data[b_tr+2]);
        end
        checks++;
        if (rise_cyc - ctrl_cyc != 3) begin
            errors++;
            $display("FAIL encode_latency: got %0d expected 3", rise_cyc - ctrl_cyc);
        end
    endtask

    task automatic test_full_channel();
        int b_tr;
        @(posedge clk);
        b_tr = n_tr;
        done_en = 1'b1; done_delay = 3; model_data = 32'h1234_5679; model_err = 2'b01;
        drive_cmd(2'b10, 2'b10, 32'h1234_5678, 32'h0000_0001);
        wait_rsp("full");
        check_rsp("full", 2'b00, 32'h1234_5679, 2'b01);
        handshake("full");
        @(posedge clk);
        checks++;
        if (n_tr - b_tr != 4) begin
            errors++;
            $display("FAIL full_count: transfers=%0d expected 4", n_tr - b_tr);
        end
        checks++;
        if (tr_addr[b_tr] !== 20'h8 || tr_data[b_tr] !== 32'h2 ||
            tr_addr[b_tr+1] !== 20'h4 || tr_data[b_tr+1] !== 32'h1234_5678 ||
            tr_addr[b_tr+2] !== 20'hC || tr_data[b_tr+2] !== 32'h1 ||
            tr_addr[b_tr+3] !== 20'h0 || tr_data[b_tr+3] !== 32'h2) begin
            errors++;
            $display("FAIL full_seq: (%h,%h) (%h,%h) (%h,%h) (%h,%h) expected (8,2) (4,12345678) (c,1) (0,2)",
                     tr_addr[b_tr], tr_data[b_tr], tr_addr[b_tr+1], tr_data[b_tr+1],
                     tr_addr[b_tr+2], tr_data[b_tr+2], tr_addr[b_tr+3], tr_data[b_tr+3]);
        end
    endtask

    task automatic test_timeout();
        done_en = 1'b0;
        drive_cmd(2'b01, 2'b01, 32'h0000_00FF, 32'h0);
        wait_rsp("timeout");
        check_rsp("timeout", 2'b01, 32'h0, 2'b00);
        handshake("timeout");
        @(posedge clk);
        checks++;
        if (rise_cyc - ctrl_cyc != 17) begin
            errors++;
            $display("FAIL timeout_latency: got %0d expected 17", rise_cyc - ctrl_cyc);
        end
    endtask

    // Done arriving on the final allowed wait cycle is a success.
    task automatic test_done_at_limit();
        done_en = 1'b1; done_delay = 16; model_data = 32'h0000_0077; model_err = 2'b10;
        drive_cmd(2'b01, 2'b00, 32'h0000_0003, 32'h0);
        wait_rsp("limit");
        check_rsp("limit", 2'b00, 32'h77, 2'b10);
        handshake("limit");
        @(posedge clk);
        checks++;
        if (rise_cyc - ctrl_cyc != 17) begin
            errors++;
            $display("FAIL limit_latency: got %0d expected 17", rise_cyc - ctrl_cyc);
        end
    endtask

    task automatic test_illegal();
        int b_tr, b_set;
        @(posedge clk);
        b_tr = n_tr; b_set = setup_cnt;
        drive_cmd(2'b11, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL illegal_rsp_next_cycle: rsp_valid got %b expected 1", rsp_valid);
        end
        check_rsp("illegal", 2'b10, 32'h0, 2'b00);
        handshake("illegal");
        @(posedge clk);
        checks++;
        if (n_tr != b_tr || setup_cnt != b_set) begin
            errors++;
            $display("FAIL illegal_no_apb: transfers=%0d setups=%0d expected 0/0", n_tr - b_tr, setup_cnt - b_set);
        end
    endtask

    task automatic test_backpressure();
        // Spurious done while idle must be ignored.
        @(negedge clk);
        spurious_done = 1'b1;
        @(negedge clk);
        spurious_done = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_spurious_done: rsp_valid=%b cmd_ready=%b expected 0/1", rsp_valid, cmd_ready);
        end
        done_en = 1'b1; done_delay = 2; model_data = 32'h0000_003C; model_err = 2'b00;
        drive_cmd(2'b00, 2'b01, 32'h0000_1234, 32'h0);
        wait_rsp("bp");
        for (int i = 0; i < 5; i++) begin
            spurious_done = (i == 2);
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || rsp_data !== 32'h3C ||
                rsp_status !== 2'b00 || rsp_errors !== 2'b00) begin
                errors++;
                $display("FAIL bp_hold_%0d: rv=%b cr=%b data=%h st=%b err=%b expected 1/0/3c/00/00",
                         i, rsp_valid, cmd_ready, rsp_data, rsp_status, rsp_errors);
            end
        end
        spurious_done = 1'b0;
        handshake("bp");
    endtask

    task automatic test_reset_mid_transfer();
        int guard;
        done_en = 1'b0;
        drive_cmd(2'b00, 2'b00, 32'h0000_0009, 32'h0);
        guard = 0;
        while (!(PSEL && PENABLE && PADDR == 20'h4) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (!(PSEL && PENABLE && PADDR == 20'h4)) begin
            errors++;
            $display("FAIL rst_find_data_access: psel=%b pen=%b paddr=%h expected 1/1/4", PSEL, PENABLE, PADDR);
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if (PSEL !== 0 || PENABLE !== 0 || PADDR !== '0 || rsp_valid !== 0 || cmd_ready !== 0) begin
            errors++;
            $display("FAIL rst_async_drop: psel=%b pen=%b paddr=%h rv=%b cr=%b expected 0", PSEL, PENABLE, PADDR, rsp_valid, cmd_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || PSEL !== 1'b0) begin
            errors++;
            $display("FAIL rst_release: cmd_ready=%b psel=%b expected 1/0", cmd_ready, PSEL);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || PSEL !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_completion: rsp_valid=%b psel=%b expected 0/0", rsp_valid, PSEL);
        end
        // Recovery: a normal command still works after the abort.
        done_en = 1'b1; done_delay = 2; model_data = 32'h0000_0042; model_err = 2'b01;
        drive_cmd(2'b01, 2'b10, 32'h0000_0042, 32'h0);
        wait_rsp("recover");
        check_rsp("recover", 2'b00, 32'h42, 2'b01);
        handshake("recover");
    endtask

    initial begin
        test_reset();
        test_encode();
        test_full_channel();
        test_timeout();
        test_done_at_limit();
        test_illegal();
        test_backpressure();
        test_reset_mid_transfer();
        @(posedge clk);
        checks++;
        if (proto_err != 0) begin
            errors++;
            $display("FAIL apb_protocol: violations=%0d expected 0", proto_err);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
